// File: rtl/usbf_mem_arb_nch.sv
// usbf_mem_arb_nch: N-channel SSRAM arbiter for the USB function core.
// Requestors share one synchronous SSRAM. The grant (ack) is combinational,
// SRAM commands are registered, and reads return a one-hot rvalid strobe
// RD_LAT+1 cycles after the grant.
// Build option: define USBF_MARB_STRICT0_EN to give channel 0 strict priority,
// with round-robin over channels 1..NCH-1. Leave it undefined to put all
// channels in one round-robin pool.
module usbf_mem_arb_nch #(
  parameter int SSRAM_HADR = 14,
  parameter int NCH        = 4,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                         phy_clk,
  input  logic                         rst,
  output logic [SSRAM_HADR:0]          sram_adr,
  output logic [DW-1:0]                sram_dout,
  input  logic [DW-1:0]                sram_din,
  output logic                         sram_we,
  output logic                         sram_re,
  input  logic [NCH-1:0]               req,
  input  logic [NCH-1:0]               we,
  input  logic [NCH*(SSRAM_HADR+1)-1:0] adr,
  input  logic [NCH*DW-1:0]            wdat,
  output logic [NCH-1:0]               ack,
  output logic [NCH-1:0]               rvalid,
  output logic [DW-1:0]                rdata
);

  localparam int AW = SSRAM_HADR + 1;
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NCH - 1);

`ifdef USBF_MARB_STRICT0_EN
  localparam logic STRICT0 = 1'b1;
`else
  localparam logic STRICT0 = 1'b0;
`endif

  // One-hot decode of a channel index
  function automatic logic [NCH-1:0] onehot(input logic [PW-1:0] idx);
    logic [NCH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [PW-1:0] ptr;
  logic [PW:0]   cand_w;
  logic          rr_vld;
  logic [PW-1:0] rr_idx;
  logic          gnt_vld;
  logic [PW-1:0] gnt_idx;
  logic          pool_gnt;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_dat;
  logic          sel_we;

  // Read-return delay line: RD_LAT stages here plus the rvalid register
  logic          rd_vld [RD_LAT];
  logic [PW-1:0] rd_ch  [RD_LAT];

  // Round-robin search starting after the pointer, wrapping explicitly at NCH
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    cand_w = '0;
    for (int off = 1; off <= NCH; off++) begin
      cand_w = {1'b0, ptr} + (PW+1)'(off);
      if (cand_w >= (PW+1)'(NCH)) begin
        cand_w = cand_w - (PW+1)'(NCH);
      end else begin
        cand_w = cand_w;
      end
      if (!rr_vld && req[cand_w[PW-1:0]] && (!STRICT0 || (cand_w[PW-1:0] != '0))) begin
        rr_vld = 1'b1;
        rr_idx = cand_w[PW-1:0];
      end else begin
        rr_vld = rr_vld;
        rr_idx = rr_idx;
      end
    end
  end

  // Final grant: channel 0 overrides the pool in strict builds; nothing in reset
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    pool_gnt = 1'b0;
    if (rst) begin
      gnt_vld = 1'b0;
    end else if (STRICT0 && req[0]) begin
      gnt_vld = 1'b1;
      gnt_idx = '0;
    end else if (rr_vld) begin
      gnt_vld  = 1'b1;
      gnt_idx  = rr_idx;
      pool_gnt = 1'b1;
    end else begin
      gnt_vld = 1'b0;
    end
  end

  assign ack    = gnt_vld ? onehot(gnt_idx) : '0;
  assign sel_we = we[gnt_idx];
  assign rdata  = sram_din;

  // Mux the granted channel's address and write data out of the flat buses
  always_comb begin
    sel_adr = '0;
    sel_dat = '0;
    for (int c = 0; c < NCH; c++) begin
      if (gnt_idx == PW'(c)) begin
        sel_adr = adr[c*AW +: AW];
        sel_dat = wdat[c*DW +: DW];
      end else begin
        sel_adr = sel_adr;
        sel_dat = sel_dat;
      end
    end
  end

  // Round-robin pointer follows pool grants only
  always_ff @(posedge phy_clk) begin
    if (rst) begin
      ptr <= PTR_RST;
    end else if (pool_gnt) begin
      ptr <= gnt_idx;
    end else begin
      ptr <= ptr;
    end
  end

  // Registered SRAM command; address and data hold when idle
  always_ff @(posedge phy_clk) begin
    if (rst) begin
      sram_adr  <= '0;
      sram_dout <= '0;
      sram_we   <= 1'b0;
      sram_re   <= 1'b0;
    end else if (gnt_vld) begin
      sram_adr  <= sel_adr;
      sram_dout <= sel_dat;
      sram_we   <= sel_we;
      sram_re   <= !sel_we;
    end else begin
      sram_we   <= 1'b0;
      sram_re   <= 1'b0;
    end
  end

  // Read-return delay line carrying valid and channel index to the rvalid strobe
  always_ff @(posedge phy_clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        rd_vld[k] <= 1'b0;
        rd_ch[k]  <= '0;
      end
      rvalid <= '0;
    end else begin
      rd_vld[0] <= gnt_vld && !sel_we;
      rd_ch[0]  <= gnt_idx;
      for (int k = 1; k < RD_LAT; k++) begin
        rd_vld[k] <= rd_vld[k-1];
        rd_ch[k]  <= rd_ch[k-1];
      end
      rvalid <= rd_vld[RD_LAT-1] ? onehot(rd_ch[RD_LAT-1]) : '0;
    end
  end

endmodule

// File: tb/tb_usbf_mem_arb_nch.sv
// Testbench for usbf_mem_arb_nch (NCH=4, RD_LAT=1). A table of per-cycle
// {req, we, expected ack} records drives the arbitration checks; read
// expectations go into a scoreboard queue and are matched against rvalid/rdata.
module tb_usbf_mem_arb_nch;
  localparam int HADR   = 14;
  localparam int NCH    = 4;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;
  localparam int AW     = HADR + 1;

  logic                phy_clk = 1'b0;
  logic                rst;
  logic [AW-1:0]       sram_adr;
  logic [DW-1:0]       sram_dout;
  logic [DW-1:0]       sram_din;
  logic                sram_we;
  logic                sram_re;
  logic [NCH-1:0]      req;
  logic [NCH-1:0]      we;
  logic [NCH*AW-1:0]   adr;
  logic [NCH*DW-1:0]   wdat;
  logic [NCH-1:0]      ack;
  logic [NCH-1:0]      rvalid;
  logic [DW-1:0]       rdata;

  usbf_mem_arb_nch #(.SSRAM_HADR(HADR), .NCH(NCH), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .phy_clk(phy_clk), .rst(rst),
    .sram_adr(sram_adr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_we(sram_we), .sram_re(sram_re),
    .req(req), .we(we), .adr(adr), .wdat(wdat),
    .ack(ack), .rvalid(rvalid), .rdata(rdata)
  );

  always #5 phy_clk = ~phy_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic mon_en  = 1'b0;
  logic mem_clr = 1'b1;

  always @(posedge phy_clk) cyc <= cyc + 1;

  logic [AW-1:0] ch_adr  [NCH];
  logic [DW-1:0] ch_wdat [NCH];

  always_comb begin
    adr  = '0;
    wdat = '0;
    for (int c = 0; c < NCH; c++) begin
      adr[c*AW +: AW]  = ch_adr[c];
      wdat[c*DW +: DW] = ch_wdat[c];
    end
  end

  // Power-on contents of the SRAM model
  function automatic logic [DW-1:0] pat(input int a);
    if (a == 32'h123) return 32'hDEAD_BEEF;
    else              return {16'hC0DE, 16'(a)};
  endfunction

  // SRAM model: writes land at the edge, reads return RD_LAT cycles after the command
  logic [DW-1:0] mem     [1024];
  logic          written [1024];
  logic [DW-1:0] rd_pipe [RD_LAT];
  always @(posedge phy_clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 1024; k++) written[k] <= 1'b0;
    end else if (sram_we) begin
      mem[sram_adr[9:0]]     <= sram_dout;
      written[sram_adr[9:0]] <= 1'b1;
    end
    rd_pipe[0] <= !sram_re ? 32'h0 :
                  (written[sram_adr[9:0]] === 1'b1) ? mem[sram_adr[9:0]] : pat(int'(sram_adr[9:0]));
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign sram_din = rd_pipe[RD_LAT-1];

  // Bench-side view of memory contents used to form expected read data
  logic [DW-1:0] shadow [1024];

  typedef struct { int due; int ch; logic [DW-1:0] data; } rd_exp_t;
  rd_exp_t sb[$];
  rd_exp_t e;

  typedef struct { logic [NCH-1:0] req; logic [NCH-1:0] we; logic [NCH-1:0] exp_ack; } vec_t;
  vec_t tbl[$];

  logic [AW-1:0] last_adr;
  logic [DW-1:0] last_dout;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard: read returns must appear exactly when due; any other rvalid is an error
  always @(negedge phy_clk) begin
    if (mon_en) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        n_vec++;
        if (rvalid !== (4'b0001 << e.ch) || rdata !== e.data) begin
          n_err++;
          $display("FAIL rvalid_rdata at cycle %0d: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                   cyc, rvalid, rdata, 4'b0001 << e.ch, e.data);
        end
      end else if (rvalid !== '0) begin
        n_vec++;
        n_err++;
        $display("FAIL rvalid_spurious at cycle %0d: got rvalid=%b, expected 0", cyc, rvalid);
      end
    end
  end

  // One cycle: drive inputs, check ack mid-cycle, check the registered command after the edge
  task automatic step(input logic [NCH-1:0] r, input logic [NCH-1:0] w,
                      input logic [NCH-1:0] exp_ack, input bit track);
    int   g;
    logic exp_we;
    logic exp_re;
    req = r;
    we  = w;
    @(negedge phy_clk);
    chk("ack", {60'd0, ack}, {60'd0, exp_ack});
    g      = -1;
    exp_we = 1'b0;
    exp_re = 1'b0;
    for (int c = 0; c < NCH; c++) if (exp_ack[c]) g = c;
    if (g >= 0) begin
      last_adr  = ch_adr[g];
      last_dout = ch_wdat[g];
      exp_we    = w[g];
      exp_re    = !w[g];
      if (w[g]) shadow[ch_adr[g][9:0]] = ch_wdat[g];
      else if (track) sb.push_back('{cyc + 1 + RD_LAT, g, shadow[ch_adr[g][9:0]]});
    end
    @(posedge phy_clk); #1;
    chk("sram_we", {63'd0, sram_we}, {63'd0, exp_we});
    chk("sram_re", {63'd0, sram_re}, {63'd0, exp_re});
    chk("sram_adr", {49'd0, sram_adr}, {49'd0, last_adr});
    chk("sram_dout", {32'd0, sram_dout}, {32'd0, last_dout});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Arbitration table; builds differ only where channel 0 competes
    tbl.push_back('{4'b1110, 4'b0000, 4'b0010});
    tbl.push_back('{4'b1110, 4'b0000, 4'b0100});
    tbl.push_back('{4'b1110, 4'b0000, 4'b1000});
    tbl.push_back('{4'b1110, 4'b0000, 4'b0010});
    tbl.push_back('{4'b1110, 4'b0000, 4'b0100});
    tbl.push_back('{4'b1110, 4'b0000, 4'b1000});
    for (int i = 0; i < 10; i++) begin
`ifdef USBF_MARB_STRICT0_EN
      tbl.push_back('{4'b0011, 4'b0000, 4'b0001});
`else
      tbl.push_back('{4'b0011, 4'b0000, (i % 2 == 0) ? 4'b0001 : 4'b0010});
`endif
    end
`ifdef USBF_MARB_STRICT0_EN
    tbl.push_back('{4'b1001, 4'b0000, 4'b0001});
`else
    tbl.push_back('{4'b1001, 4'b0000, 4'b1000});
`endif
    tbl.push_back('{4'b0101, 4'b0000, 4'b0001});
    tbl.push_back('{4'b1100, 4'b0000, 4'b0100});
    tbl.push_back('{4'b1100, 4'b0000, 4'b1000});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0001, 4'b0000, 4'b0001});
    tbl.push_back('{4'b0110, 4'b0000, 4'b0010});
`ifdef USBF_MARB_STRICT0_EN
    tbl.push_back('{4'b1111, 4'b0000, 4'b0001});
`else
    tbl.push_back('{4'b1111, 4'b0000, 4'b0100});
`endif

    for (int k = 0; k < 1024; k++) shadow[k] = pat(k);
    for (int c = 0; c < NCH; c++) begin
      ch_adr[c]  = 15'(32'h100 + c);
      ch_wdat[c] = 32'h1000_0000 + c;
    end

    // Reset with all requests raised: no ack may be issued
    rst = 1'b1;
    req = '1;
    we  = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge phy_clk);
      chk("ack_during_reset", {60'd0, ack}, 64'd0);
    end
    @(posedge phy_clk); #1;
    rst     = 1'b0;
    mem_clr = 1'b0;
    req     = '0;
    mon_en  = 1'b1;
    last_adr  = '0;
    last_dout = '0;
    chk("reset_sram_adr", {49'd0, sram_adr}, 64'd0);
    chk("reset_sram_dout", {32'd0, sram_dout}, 64'd0);
    chk("reset_sram_we", {63'd0, sram_we}, 64'd0);
    chk("reset_sram_re", {63'd0, sram_re}, 64'd0);
    chk("reset_rvalid", {60'd0, rvalid}, 64'd0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i].req, tbl[i].we, tbl[i].exp_ack, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Single read of the preloaded word
    ch_adr[2] = 15'h0123;
    step(4'b0100, 4'b0000, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Write on ch1 then read of the same word on ch3 in the next cycle
    ch_adr[1]  = 15'h0010;
    ch_wdat[1] = 32'hA5A5_A5A5;
    ch_adr[3]  = 15'h0010;
    step(4'b0010, 4'b0010, 4'b0010, 1'b1);
    step(4'b1000, 4'b0000, 4'b1000, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Read on ch2, then reset in the next cycle: the read must never return
    step(4'b0100, 4'b0000, 4'b0100, 1'b0);
    rst = 1'b1;
    req = 4'b0110;
    @(negedge phy_clk);
    chk("ack_in_midreset", {60'd0, ack}, 64'd0);
    @(posedge phy_clk); #1;
    rst = 1'b0;
    req = '0;
    last_adr  = '0;
    last_dout = '0;
    chk("midreset_sram_re", {63'd0, sram_re}, 64'd0);
    chk("midreset_sram_adr", {49'd0, sram_adr}, 64'd0);
    for (int i = 0; i < RD_LAT + 2; i++) begin
      @(negedge phy_clk);
      chk("rvalid_after_reset", {60'd0, rvalid}, 64'd0);
      @(posedge phy_clk); #1;
    end
    // Pointer back at NCH-1: ch1 beats ch3
    step(4'b1010, 4'b0000, 4'b0010, 1'b1);
    for (int i = 0; i < RD_LAT + 3; i++) step(4'b0000, 4'b0000, 4'b0000, 1'b1);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usbf_mem_arb_nch.md
Name: usbf_mem_arb_nch

Overview:
- Parametrised N-channel SSRAM arbiter for the USB function core; successor to the two-port IDMA/WISHBONE memory arbiter.
- Any number of requestors (IDMA, WISHBONE, future DMA or debug ports) share one synchronous SSRAM.
- Channel 0 can keep strict priority; the remaining channels share round-robin arbitration.
- Adds registered SRAM command outputs, configurable read latency and per-channel read-data-valid strobes.

Parameters:
- SSRAM_HADR, 14, MSB of SRAM word address (address width SSRAM_HADR+1).
- NCH, 4, number of requesting channels (2..8).
- DW, 32, data width.
- RD_LAT, 1, SRAM cycles from registered command to valid sram_din (1..3).

Ports:
- phy_clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- sram_adr  out  SSRAM_HADR+1  registered SRAM address.
- sram_dout  out  DW  registered SRAM write data.
- sram_din  in  DW  SRAM read data.
- sram_we  out  1  registered write enable.
- sram_re  out  1  registered read enable.
- req  in  NCH  per-channel access request; held until ack.
- we  in  NCH  per-channel write qualifier; 1 = write.
- adr  in  NCH*(SSRAM_HADR+1)  flattened addresses; channel i in slice i.
- wdat  in  NCH*DW  flattened write data.
- ack  out  NCH  combinational one-hot grant; access accepted this cycle.
- rvalid  out  NCH  one-hot read-data-valid strobe.
- rdata  out  DW  read data, equal to sram_din; qualified by rvalid.

Behaviour:
- Reset values: sram_adr=0, sram_dout=0, sram_we=0, sram_re=0, rvalid=0, read pipeline cleared, round-robin pointer=NCH-1.
- ack is combinational. At most one bit is set, and only for a channel whose req is high.
- A requestor may present its next access in the cycle after ack. Back-to-back grants to the same channel are legal.
- Arbitration (each cycle, cycle t):
  - Strict mode (see Optional Feature): req[0] wins unconditionally. Otherwise the winner is found by round-robin over channels 1..NCH-1.
  - Round-robin mode: all 0..NCH-1 are in the pool.
  - The search starts at pointer+1, wraps modulo NCH, and skips channel 0 when in strict mode.
  - The pointer is updated to the granted index only when a pool channel is granted. A channel-0 strict grant leaves the pointer unchanged.
- Command stage, on the clock edge ending cycle t when grant g exists:
  - sram_adr <= adr[g], sram_dout <= wdat[g].
  - sram_we <= we[g], sram_re <= !we[g].
  - With no grant: sram_we=0, sram_re=0, and sram_adr/sram_dout hold their previous values.
- Read return:
  - A read granted in cycle t asserts rvalid[g] in cycle t+1+RD_LAT for exactly one cycle.
  - rdata=sram_din in that cycle.
  - Implemented as a delay line, RD_LAT+1 stages deep, carrying a valid bit and the channel index. Throughput is one read per cycle.
- Writes produce no rvalid. Read-after-write to the same address from any channel returns the new data, because commands are issued in grant order.
- Simultaneous requests are resolved purely by the rules above. Losing channels keep req high with no timeout.
- Starvation: in strict mode, continuous req[0] starves channels 1..NCH-1 by design (IDMA-first policy).
- Reset mid-operation: in-flight reads are discarded with no rvalid, the pointer returns to NCH-1, and no ack is issued while rst=1.
- The pointer is $clog2(NCH) bits. Wrap from NCH-1 to 0 is explicit; it is not a power-of-two overflow.

Optional Feature:
- Macro USBF_MARB_STRICT0_EN.
- Defined: channel 0 has strict priority over all others, and round-robin applies to channels 1..NCH-1.
- Undefined: all NCH channels are in a single round-robin pool with equal priority.
- Port list and timing are identical in both builds.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, then no req -> all outputs 0, pointer=NCH-1, no ack.
- Single read: ch2 reads adr 0x0123, RD_LAT=1, SRAM model returns 0xDEADBEEF -> ack[2] in t, sram_re=1 with sram_adr=0x0123 in t+1, rvalid[2]=1 with rdata=0xDEADBEEF in t+2.
- Round-robin fairness, strict build, NCH=4: req[3:1] held continuously -> grant order 1,2,3,1,2,3; each channel gets exactly 1/3 of cycles.
- Strict priority: req[0] plus req[1] held for 10 cycles, strict build -> ack[0] every cycle, ack[1]=0. Non-strict build -> ack alternates 0,1.
- Write/read ordering: ch1 writes 0xA5A5A5A5 to 0x0010, then ch3 reads 0x0010 in the next cycle -> sram_we then sram_re in consecutive cycles, rvalid[3] with rdata=0xA5A5A5A5.
- Reset mid-read: read granted with RD_LAT=3, rst pulsed 1 cycle later -> no rvalid ever appears, and the first post-reset pool grant goes to the lowest-index requesting pool channel.
